// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: forwarding selects,
// load-use stall, MEM-resolved branch flush and data-RAM freeze. Perf counters under HAZ_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            br_taken_mem,
    input  logic            mem_busy,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_clr,
    output logic            idex_clr,
    output logic            exmem_clr,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            id_byp_a,
    output logic            id_byp_b,
    output logic [1:0]      state
`ifdef HAZ_PERF_CNT_EN
   ,output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
`endif
);

    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10, FREEZE = 2'b11} state_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic            memread;
    } ex_ent_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic            memread;
    } mem_ent_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            regwrite;
    } wb_ent_t;

    ex_ent_t  ex_q;
    mem_ent_t mem_q;
    wb_ent_t  wb_q;
    state_t   state_q;
    state_t   win;
    logic     load_use, mem_wr, wb_wr;

    assign mem_wr = mem_q.valid & mem_q.regwrite & (mem_q.rd != '0);
    assign wb_wr  = wb_q.valid & wb_q.regwrite & (wb_q.rd != '0);

    assign load_use = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
                      ((id_use_rs1 & (ex_q.rd == id_rs1)) | (id_use_rs2 & (ex_q.rd == id_rs2)));

    always_comb begin
        win = RUN;
        if (mem_busy)          win = FREEZE;
        else if (br_taken_mem) win = FLUSH;
        else if (load_use)     win = STALL;
    end

    assign pc_en     = (win != FREEZE) && (win != STALL);
    assign ifid_en   = (win != FREEZE) && (win != STALL);
    assign idex_en   = (win != FREEZE);
    assign exmem_en  = (win != FREEZE);
    assign memwb_en  = (win != FREEZE);
    assign ifid_clr  = (win == FLUSH);
    assign idex_clr  = (win == FLUSH) || (win == STALL);
    assign exmem_clr = (win == FLUSH);

    // A load sitting in MEM has no result yet, so it is never a 10 source;
    // that is what limits a load-use hazard to a single bubble.
    always_comb begin
        fwd_a = 2'b00;
        if (mem_wr && !mem_q.memread && (mem_q.rd == ex_q.rs1)) fwd_a = 2'b10;
        else if (wb_wr && (wb_q.rd == ex_q.rs1))                fwd_a = 2'b01;
        fwd_b = 2'b00;
        if (mem_wr && !mem_q.memread && (mem_q.rd == ex_q.rs2)) fwd_b = 2'b10;
        else if (wb_wr && (wb_q.rd == ex_q.rs2))                fwd_b = 2'b01;
    end

    assign id_byp_a = wb_wr & id_use_rs1 & (wb_q.rd == id_rs1);
    assign id_byp_b = wb_wr & id_use_rs2 & (wb_q.rd == id_rs2);

    // Cleared entries are zeroed entirely so a bubble never matches a forwarding compare.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            if (idex_en)
                ex_q <= idex_clr ? '0 :
                        '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                          regwrite: id_regwrite, memread: id_memread};
            if (exmem_en)
                mem_q <= exmem_clr ? '0 :
                         '{valid: ex_q.valid, rd: ex_q.rd,
                           regwrite: ex_q.regwrite, memread: ex_q.memread};
            if (memwb_en)
                wb_q <= '{valid: mem_q.valid, rd: mem_q.rd, regwrite: mem_q.regwrite};
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= RUN;
        else          state_q <= win;
    end

    assign state = state_q;

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (win == STALL  && stall_cnt  != '1) stall_cnt  <= stall_cnt + 1'b1;
            if (win == FLUSH  && flush_cnt  != '1) flush_cnt  <= flush_cnt + 1'b1;
            if (win == FREEZE && freeze_cnt != '1) freeze_cnt <= freeze_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a pipeline-of-instructions reference model predicts
// each cycle's control outputs; a monitor compares them on the falling edge.
module tb_hazard_ctrl;
    localparam int RA_W = 5;

    logic CLK = 1'b0, RESET_N = 1'b0;
    logic id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, br_taken_mem, mem_busy;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr, exmem_clr;
    logic [1:0] fwd_a, fwd_b, state;
    logic id_byp_a, id_byp_b;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

    hazard_ctrl #(.RA_W(RA_W), .CNT_W(32)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .br_taken_mem(br_taken_mem), .mem_busy(mem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_clr(ifid_clr), .idex_clr(idex_clr), .exmem_clr(exmem_clr),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b), .state(state)
`ifdef HAZ_PERF_CNT_EN
       ,.stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model: the instruction occupying each back-end stage.
    typedef struct {bit valid; int rs1; int rs2; int rd; bit rw; bit mr;} ins_t;
    typedef struct {int en; int clr; int fa; int fb; int ba; int bb; int st; int sc; int fc; int zc;} exp_t;

    localparam int M_RUN = 0, M_STALL = 1, M_FLUSH = 2, M_FREEZE = 3;

    ins_t ex, mem, wb, blank;
    int   prev_mode, n_stall, n_flush, n_freeze;
    exp_t q[$];
    int   checks = 0, failures = 0;

    function automatic bit writes(ins_t x);
        return x.valid && x.rw && x.rd != 0;
    endfunction

    function automatic int sel(int rs);
        if (writes(mem) && !mem.mr && mem.rd == rs) return 2;
        if (writes(wb) && wb.rd == rs) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        blank = '{0, 0, 0, 0, 0, 0};
        ex = blank; mem = blank; wb = blank;
        prev_mode = M_RUN; n_stall = 0; n_flush = 0; n_freeze = 0;
    endtask

    // Predict this cycle's outputs from the applied inputs, then retire the cycle in the model.
    task automatic issue();
        exp_t e;
        bit   hz;
        int   mode;
        hz = id_valid && ex.valid && ex.mr && ex.rd != 0 &&
             ((id_use_rs1 && ex.rd == int'(id_rs1)) || (id_use_rs2 && ex.rd == int'(id_rs2)));
        mode = mem_busy ? M_FREEZE : br_taken_mem ? M_FLUSH : hz ? M_STALL : M_RUN;
        e.en  = (mode == M_FREEZE) ? 0 : (mode == M_STALL) ? 5'b00111 : 5'b11111;
        e.clr = (mode == M_FLUSH) ? 3'b111 : (mode == M_STALL) ? 3'b010 : 0;
        e.fa  = sel(ex.rs1);
        e.fb  = sel(ex.rs2);
        e.ba  = int'(writes(wb) && id_use_rs1 && wb.rd == int'(id_rs1));
        e.bb  = int'(writes(wb) && id_use_rs2 && wb.rd == int'(id_rs2));
        e.st  = prev_mode;
        e.sc  = n_stall; e.fc = n_flush; e.zc = n_freeze;
        q.push_back(e);
        if (mode != M_FREEZE) begin
            wb  = mem;
            mem = (mode == M_FLUSH) ? blank : ex;
            ex  = (mode != M_RUN) ? blank :
                  '{id_valid, int'(id_rs1), int'(id_rs2), int'(id_rd), id_regwrite, id_memread};
        end
        prev_mode = mode;
        if (mode == M_STALL)  n_stall++;
        if (mode == M_FLUSH)  n_flush++;
        if (mode == M_FREEZE) n_freeze++;
    endtask

    task automatic set_in(bit v, int r1, int r2, bit u1, bit u2, int rd, bit rw, bit mr, bit br, bit busy);
        id_valid = v; id_rs1 = r1[RA_W-1:0]; id_rs2 = r2[RA_W-1:0]; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd[RA_W-1:0]; id_regwrite = rw; id_memread = mr; br_taken_mem = br; mem_busy = busy;
    endtask

    task automatic step(bit v, int r1, int r2, bit u1, bit u2, int rd, bit rw, bit mr, bit br, bit busy);
        @(posedge CLK); #2;
        set_in(v, r1, r2, u1, u2, rd, rw, mr, br, busy);
        issue();
    endtask

    task automatic do_reset();
        @(posedge CLK); #2;
        RESET_N = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        issue();
        @(negedge CLK); #1;
        RESET_N = 1'b1;
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("enables", int'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), e.en);
            chk("clears", int'({ifid_clr, idex_clr, exmem_clr}), e.clr);
            chk("fwd_a", int'(fwd_a), e.fa);
            chk("fwd_b", int'(fwd_b), e.fb);
            chk("id_byp_a", int'(id_byp_a), e.ba);
            chk("id_byp_b", int'(id_byp_b), e.bb);
            chk("state", int'(state), e.st);
`ifdef HAZ_PERF_CNT_EN
            chk("stall_cnt", int'(stall_cnt), e.sc);
            chk("flush_cnt", int'(flush_cnt), e.fc);
            chk("freeze_cnt", int'(freeze_cnt), e.zc);
`endif
        end
    end

    task automatic random_cycles(int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        do_reset();
        // ADDI x1 then ADD x2,x1,x3: MEM->EX forward of rs1
        step(1, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        step(1, 1, 3, 1, 1, 2, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // LW x5 then ADD x6,x5,x5: one bubble, then WB forward
        step(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
        step(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
        step(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // taken branch coinciding with a load-use hazard
        step(1, 2, 0, 1, 0, 7, 1, 1, 0, 0);
        step(1, 7, 0, 1, 0, 8, 1, 0, 1, 0);
        step(1, 7, 0, 1, 0, 8, 1, 0, 1, 0);
        // freeze for 3 cycles with a taken branch pending, then the flush
        repeat (3) step(1, 1, 2, 1, 1, 3, 1, 0, 1, 1);
        step(1, 1, 2, 1, 1, 3, 1, 0, 1, 0);
        // x0 writers (including a load) never forward, bypass or stall
        step(1, 0, 0, 1, 1, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        random_cycles(800);
        // reset while a stall is pending
        step(1, 1, 0, 1, 0, 1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 1, 2, 1, 0, 0, 0);
        do_reset();
        random_cycles(800);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
        #1;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses left unchecked, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
